// File: rtl/nexys_starship_pkg.sv
// -----------------------------------------------------------------------------
// nexys_starship_pkg
// Shared definitions for the Nexys Starship game blocks:
//   - one-hot FSM state encoding used by the hazard scheduler
//   - room index constants (right, left, up, down)
//   - 16-bit Fibonacci LFSR tap mask and feedback helper
//   - repair-combination helper that never yields the cleared value 0
// -----------------------------------------------------------------------------
package nexys_starship_pkg;

    // One-hot, 3 bits, same style as the other starship FSMs.
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_ARM  = 3'b010,
        ST_FIRE = 3'b100
    } hazard_state_t;

    localparam logic [1:0] ROOM_R = 2'd0;
    localparam logic [1:0] ROOM_L = 2'd1;
    localparam logic [1:0] ROOM_U = 2'd2;
    localparam logic [1:0] ROOM_D = 2'd3;

    // Taps 16,14,13,11 -> state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

    function automatic logic lfsr_feedback(input logic [15:0] s);
        return ^(s & LFSR_TAP_MASK);
    endfunction

    // A repair combination of 0 would look like an already-cleared room.
    function automatic logic [3:0] hex_nonzero(input logic [3:0] h);
        return (h == 4'h0) ? 4'hF : h;
    endfunction

endpackage

// File: rtl/nexys_starship_lfsr16.sv
// -----------------------------------------------------------------------------
// nexys_starship_lfsr16
// Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), advancing every Clk.
// Ports:
//   Clk        in  system clock
//   Reset      in  asynchronous reset, active-low (loads SEED)
//   lfsr_state out 16-bit current LFSR state
// Parameter:
//   SEED       reset value, must be nonzero
// -----------------------------------------------------------------------------
module nexys_starship_lfsr16
    import nexys_starship_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic [15:0] lfsr_state
);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            lfsr_state <= SEED;
        end else begin
            lfsr_state <= {lfsr_state[14:0], lfsr_feedback(lfsr_state)};
        end
    end

endmodule

// File: rtl/nexys_starship_hazard_gen.sv
// -----------------------------------------------------------------------------
// nexys_starship_hazard_gen
// Hazard scheduler: decides when a room breaks and which one. Counts game
// ticks down from a level-dependent interval, then picks a room from the LFSR,
// skipping rooms already broken, and issues a one-cycle break request plus a
// shared 4-bit repair combination.
//
// Ports:
//   Clk            in  system clock
//   Reset          in  asynchronous reset, active-low
//   play_flag      in  game start request
//   gameover_ctrl  in  game over, aborts scheduling (highest priority)
//   timer_tick     in  one-Clk-wide game-time tick
//   broken[3:0]    in  per-room broken flags {down, up, left, right}
//   RR_random      out break request, right room (1 Clk)
//   RL_random      out break request, left room  (1 Clk)
//   RU_random      out break request, up room    (1 Clk)
//   RD_random      out break request, down room  (1 Clk)
//   random_hex[3:0] out repair combination of the most recent hazard
//   level[2:0]     out current difficulty level
//
// Configuration macro HAZARD_RAMP_EN:
//   defined   - level rises every LEVEL_TICKS ticks, interval shrinks to
//               max(BASE_INTERVAL - level, MIN_INTERVAL)
//   undefined - no tick counter, level tied to 0, interval = BASE_INTERVAL
// -----------------------------------------------------------------------------
module nexys_starship_hazard_gen
    import nexys_starship_pkg::*;
#(
    parameter int unsigned BASE_INTERVAL = 8,
    parameter int unsigned MIN_INTERVAL  = 2,
    parameter int unsigned LEVEL_TICKS   = 16,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       play_flag,
    input  logic       gameover_ctrl,
    input  logic       timer_tick,
    input  logic [3:0] broken,
    output logic       RR_random,
    output logic       RL_random,
    output logic       RU_random,
    output logic       RD_random,
    output logic [3:0] random_hex,
    output logic [2:0] level
);

    hazard_state_t state;
    hazard_state_t state_nxt;

    logic [15:0] lfsr;
    logic [3:0]  count;
    logic [3:0]  interval;
    logic [2:0]  level_q;

    logic [1:0]  fire_room;
    logic        room_found;

    logic [3:0]  pulse_q;
    logic [3:0]  pulse_nxt;
    logic        hex_load;
    logic        load_count;
    logic        dec_count;

    // Only bits [7:4] and [1:0] of the LFSR are consumed.
    logic        unused_lfsr_bits;
    assign unused_lfsr_bits = ^{lfsr[15:8], lfsr[3:2]};

    // -------------------------------------------------------------------------
    // Random source
    // -------------------------------------------------------------------------
    nexys_starship_lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .Clk        (Clk),
        .Reset      (Reset),
        .lfsr_state (lfsr)
    );

    // -------------------------------------------------------------------------
    // Difficulty level and hazard interval
    // -------------------------------------------------------------------------
`ifdef HAZARD_RAMP_EN
    localparam int unsigned TICK_W   = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(LEVEL_TICKS - 1);
    localparam logic [4:0] BASE5 = 5'(BASE_INTERVAL);
    localparam logic [4:0] MIN5  = 5'(MIN_INTERVAL);

    logic [TICK_W-1:0] tick_cnt;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            tick_cnt <= '0;
            level_q  <= '0;
        end else if (gameover_ctrl) begin
            tick_cnt <= '0;
            level_q  <= '0;
        end else if (timer_tick && (state == ST_ARM || state == ST_FIRE)) begin
            if (tick_cnt == TICK_LAST) begin
                tick_cnt <= '0;
                if (level_q != 3'd7) begin
                    level_q <= level_q + 3'd1;
                end
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

    // Compare in 5 bits so BASE - level can never wrap below the floor.
    always_comb begin
        interval = BASE5[3:0] - {1'b0, level_q};
        if (BASE5 <= ({2'b00, level_q} + MIN5)) begin
            interval = MIN5[3:0];
        end
    end
`else
    localparam logic [3:0] BASE4 = 4'(BASE_INTERVAL);

    logic [31:0] unused_ramp_params;
    assign unused_ramp_params = LEVEL_TICKS ^ MIN_INTERVAL;

    assign level_q  = '0;
    assign interval = BASE4;
`endif

    assign level = level_q;

    // -------------------------------------------------------------------------
    // Room selection: start at LFSR[1:0], rotate upward to first unbroken room
    // -------------------------------------------------------------------------
    always_comb begin
        logic [1:0] rot_idx;
        room_found = 1'b0;
        fire_room  = lfsr[1:0];
        rot_idx    = lfsr[1:0];
        for (int unsigned i = 0; i < 4; i++) begin
            rot_idx = lfsr[1:0] + 2'(i);
            if (!room_found && !broken[rot_idx]) begin
                room_found = 1'b1;
                fire_room  = rot_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        if (gameover_ctrl) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (play_flag)                      state_nxt = ST_ARM;
                ST_ARM:  if (timer_tick && count == 4'd1)    state_nxt = ST_FIRE;
                ST_FIRE: if (room_found)                     state_nxt = ST_ARM;
                default:                                     state_nxt = ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs / datapath controls
    // -------------------------------------------------------------------------
    always_comb begin
        pulse_nxt  = '0;
        hex_load   = 1'b0;
        load_count = 1'b0;
        dec_count  = 1'b0;
        if (!gameover_ctrl) begin
            case (state)
                ST_IDLE: load_count = play_flag;
                ST_ARM:  dec_count  = timer_tick && (count != 4'd0);
                ST_FIRE: begin
                    if (room_found) begin
                        pulse_nxt[fire_room] = 1'b1;
                        hex_load             = 1'b1;
                        load_count           = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Registered datapath and outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            count      <= '0;
            pulse_q    <= '0;
            random_hex <= '0;
        end else begin
            pulse_q <= pulse_nxt;
            if (gameover_ctrl) begin
                count <= '0;
            end else if (load_count) begin
                count <= interval;
            end else if (dec_count) begin
                count <= count - 4'd1;
            end
            // random_hex deliberately survives gameover.
            if (hex_load) begin
                random_hex <= hex_nonzero(lfsr[7:4]);
            end
        end
    end

    assign RR_random = pulse_q[ROOM_R];
    assign RL_random = pulse_q[ROOM_L];
    assign RU_random = pulse_q[ROOM_U];
    assign RD_random = pulse_q[ROOM_D];

endmodule
